// File: rtl/tjmono_rx_merge.sv
// Round-robin merge of CHANNELS first-word-fall-through FIFOs into a single
// registered output stream, with an optional channel tag and a per-grant burst limit.
module tjmono_rx_merge #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_BITS   = 3,
  parameter int TAG_ENABLE = 1,
  parameter int BURST      = 4
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic [CHANNELS-1:0]            IN_EMPTY,
  input  logic [CHANNELS-1:0]            IN_HOLD,
  input  logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA,
  output logic [CHANNELS-1:0]            IN_READ,
  input  logic                           OUT_READY,
  output logic                           OUT_VALID,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic [CHANNELS-1:0]            GRANT,
  output logic [31:0]                    WORD_CNT
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (BURST > 0) ? $clog2(BURST + 1) : 1;
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] BURST_C   = CNT_W'(BURST);
  localparam bit               HAS_LIMIT = (BURST > 32'sd0);
  localparam bit               TAG_ON    = (TAG_ENABLE != 32'sd0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [CHANNELS-1:0] one_hot(input logic [CH_W-1:0] ch);
    logic [CHANNELS-1:0] v;
    v     = {CHANNELS{1'b0}};
    v[ch] = 1'b1;
    return v;
  endfunction

  // The tag replaces the top TAG_BITS of the input word.
  function automatic logic [DATA_WIDTH-1:0] tag_word(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [CH_W-1:0]       ch);
    logic [DATA_WIDTH-1:0] r;
    if (TAG_ON) begin
      r = {TAG_BITS'(ch), w[DATA_WIDTH-TAG_BITS-1:0]};
    end else begin
      r = w;
    end
    return r;
  endfunction

  state_t                 state_r, state_n;
  logic [CH_W-1:0]        ch_r, ch_n;
  logic [CNT_W-1:0]       burst_cnt_r, cnt_n;
  logic [CHANNELS-1:0]    grant_r, grant_n;
  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic [31:0]            word_cnt_r;
  logic [CH_W-1:0]        sel_s, idx_s;
  logic                   any_s, load_s, at_limit_s, cur_empty_s, cur_hold_s, pop_s;
  logic [DATA_WIDTH-1:0]  words_s [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_words
    assign words_s[g] = IN_DATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan downward so the closest channel after ch_r wins.
  always_comb begin
    sel_s = ch_r;
    idx_s = ch_r;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx_s = CH_W'((int'(ch_r) + i) % CHANNELS);
      sel_s = IN_EMPTY[idx_s] ? sel_s : idx_s;
    end
  end

  assign any_s       = ~&IN_EMPTY;
  assign load_s      = ~out_valid_r | OUT_READY;
  assign at_limit_s  = HAS_LIMIT && (burst_cnt_r >= BURST_C);
  assign cur_empty_s = IN_EMPTY[ch_r];
  assign cur_hold_s  = IN_HOLD[ch_r];

  // Next-state, burst counter and pop decision.
  always_comb begin
    state_n = state_r;
    ch_n    = ch_r;
    cnt_n   = burst_cnt_r;
    grant_n = grant_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_n = ST_GRANT;
          ch_n    = sel_s;
          cnt_n   = {CNT_W{1'b0}};
          grant_n = one_hot(sel_s);
        end else begin
          state_n = ST_IDLE;
          grant_n = {CHANNELS{1'b0}};
        end
      end
      ST_GRANT: begin
        // Hold overrides the burst limit; the counter saturates at BURST.
        pop_s = ~BUS_RST & load_s & ~cur_empty_s & (~at_limit_s | cur_hold_s);
        if (pop_s && !at_limit_s) begin
          cnt_n = burst_cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_n = burst_cnt_r;
        end
        if (!cur_hold_s && (cur_empty_s || (HAS_LIMIT && (cnt_n >= BURST_C)))) begin
          state_n = ST_IDLE;
          grant_n = {CHANNELS{1'b0}};
        end else begin
          state_n = ST_GRANT;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = {CHANNELS{1'b0}};
      end
    endcase
  end

  // Arbiter state; ch_r also serves as the last-granted channel.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r     <= ST_IDLE;
      ch_r        <= CH_LAST;
      burst_cnt_r <= {CNT_W{1'b0}};
      grant_r     <= {CHANNELS{1'b0}};
    end else begin
      state_r     <= state_n;
      ch_r        <= ch_n;
      burst_cnt_r <= cnt_n;
      grant_r     <= grant_n;
    end
  end

  // Output word register and transfer counter.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      word_cnt_r  <= 32'd0;
    end else begin
      if (load_s) begin
        out_valid_r <= pop_s;
        out_data_r  <= pop_s ? tag_word(words_s[ch_r], ch_r) : out_data_r;
      end else begin
        out_valid_r <= out_valid_r;
        out_data_r  <= out_data_r;
      end
      if (out_valid_r && OUT_READY) begin
        word_cnt_r <= word_cnt_r + 32'd1;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

  assign IN_READ   = pop_s ? one_hot(ch_r) : {CHANNELS{1'b0}};
  assign OUT_VALID = out_valid_r;
  assign OUT_DATA  = out_data_r;
  assign GRANT     = grant_r;
  assign WORD_CNT  = word_cnt_r;

endmodule
